// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: time-set controller for a BCD hh:mm clock.
//   Holds a shadow copy of the time that the user edits with btn_mode/btn_inc.
//   The shadow is written into the time counter with a one-cycle load strobe.
//
// Ports
//   clock, reset          : single clock, synchronous active-high reset
//   tick                  : one-cycle minute pulse (counting time base)
//   btn_mode, btn_inc     : debounced one-cycle button pulses
//   time_ms_hr/ls_hr/ms_min/ls_min : current BCD time from the counter
//   cnt_en                : count enable, tick passed through only in RUN (combinational)
//   load                  : one-cycle load strobe (high in COMMIT)
//   load_ms_hr/ls_hr/ms_min/ls_min : shadow BCD time, always driven
//   mode                  : 00 RUN, 01 SET_HR, 10 SET_MIN, 11 COMMIT
//   blink                 : blink for the field being edited
//
// Configuration
//   CLOCK_SET_CTRL_TIMEOUT_EN : when defined, an 8-bit idle counter cancels a
//   set session after TIMEOUT_TICKS ticks without a button press.
module clock_set_ctrl #(
  parameter int unsigned TIMEOUT_TICKS = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [1:0] time_ms_hr,
  input  logic [3:0] time_ls_hr,
  input  logic [2:0] time_ms_min,
  input  logic [3:0] time_ls_min,
  output logic       cnt_en,
  output logic       load,
  output logic [1:0] load_ms_hr,
  output logic [3:0] load_ls_hr,
  output logic [2:0] load_ms_min,
  output logic [3:0] load_ls_min,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int unsigned MS_HR_W  = 2;
  localparam int unsigned LS_W     = 4;
  localparam int unsigned MS_MIN_W = 3;
  localparam int unsigned IDLE_W   = 8;

  // Parameter range guard, evaluated at elaboration.
  if (TIMEOUT_TICKS < 1 || TIMEOUT_TICKS > 255) begin : g_bad_timeout
    $error("clock_set_ctrl: TIMEOUT_TICKS must be in 1..255");
  end

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_HR  = 2'b01,
    ST_SET_MIN = 2'b10,
    ST_COMMIT  = 2'b11
  } state_e;

  state_e               state_q,     state_d;
  logic                 load_q,      load_d;
  logic                 blink_q,     blink_d;
  logic [MS_HR_W-1:0]   ms_hr_q,     ms_hr_d;
  logic [LS_W-1:0]      ls_hr_q,     ls_hr_d;
  logic [MS_MIN_W-1:0]  ms_min_q,    ms_min_d;
  logic [LS_W-1:0]      ls_min_q,    ls_min_d;
  logic [MS_HR_W+LS_W-1:0]  hr_next;
  logic [MS_MIN_W+LS_W-1:0] min_next;

`ifdef CLOCK_SET_CTRL_TIMEOUT_EN
  localparam logic [IDLE_W-1:0] TIMEOUT_LIM = IDLE_W'(TIMEOUT_TICKS);
  logic [IDLE_W-1:0]    idle_q,      idle_d;
`endif

  // Hour +1 in BCD, 00..23; anything at or beyond 23 (or malformed) wraps to 00.
  function automatic logic [MS_HR_W+LS_W-1:0] hr_inc(input logic [MS_HR_W-1:0] ms,
                                                     input logic [LS_W-1:0]    ls);
    if (ms > 2'd2 || ls > 4'd9 || (ms == 2'd2 && ls >= 4'd3)) begin
      return '0;
    end else if (ls == 4'd9) begin
      return {ms + 2'd1, 4'd0};
    end else begin
      return {ms, ls + 4'd1};
    end
  endfunction

  // Minute +1 in BCD, 00..59; 59 (or malformed) wraps to 00.
  function automatic logic [MS_MIN_W+LS_W-1:0] min_inc(input logic [MS_MIN_W-1:0] ms,
                                                       input logic [LS_W-1:0]     ls);
    if (ms > 3'd5 || ls > 4'd9 || (ms == 3'd5 && ls == 4'd9)) begin
      return '0;
    end else if (ls == 4'd9) begin
      return {ms + 3'd1, 4'd0};
    end else begin
      return {ms, ls + 4'd1};
    end
  endfunction

  assign hr_next  = hr_inc(ms_hr_q, ls_hr_q);
  assign min_next = min_inc(ms_min_q, ls_min_q);

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    load_d   = 1'b0;
    blink_d  = blink_q;
    ms_hr_d  = ms_hr_q;
    ls_hr_d  = ls_hr_q;
    ms_min_d = ms_min_q;
    ls_min_d = ls_min_q;
`ifdef CLOCK_SET_CTRL_TIMEOUT_EN
    idle_d   = idle_q;
`endif

    case (state_q)
      ST_RUN: begin
        blink_d = 1'b0;
`ifdef CLOCK_SET_CTRL_TIMEOUT_EN
        idle_d  = '0;
`endif
        if (btn_mode) begin
          // Snapshot the running time as the starting point for editing.
          state_d  = ST_SET_HR;
          ms_hr_d  = time_ms_hr;
          ls_hr_d  = time_ls_hr;
          ms_min_d = time_ms_min;
          ls_min_d = time_ls_min;
        end
      end

      ST_SET_HR, ST_SET_MIN: begin
        if (btn_mode) begin
          // btn_mode wins over btn_inc and tick in the same cycle.
          state_d = (state_q == ST_SET_HR) ? ST_SET_MIN : ST_COMMIT;
          load_d  = (state_q == ST_SET_MIN);
          blink_d = 1'b0;
`ifdef CLOCK_SET_CTRL_TIMEOUT_EN
          idle_d  = '0;
`endif
        end else begin
          if (btn_inc) begin
            if (state_q == ST_SET_HR) begin
              {ms_hr_d, ls_hr_d} = hr_next;
            end else begin
              {ms_min_d, ls_min_d} = min_next;
            end
          end
          if (tick) begin
            blink_d = ~blink_q;
          end
`ifdef CLOCK_SET_CTRL_TIMEOUT_EN
          // A button press restarts the idle window; the tick is not counted.
          if (btn_inc) begin
            idle_d = '0;
          end else if (tick) begin
            if ((idle_q + 8'd1) >= TIMEOUT_LIM) begin
              state_d = ST_RUN;
              blink_d = 1'b0;
              idle_d  = '0;
            end else begin
              idle_d  = idle_q + 8'd1;
            end
          end
`endif
        end
      end

      ST_COMMIT: begin
        state_d = ST_RUN;
        blink_d = 1'b0;
      end

      default: begin
        state_d = ST_RUN;
        blink_d = 1'b0;
      end
    endcase
  end

  // State and shadow registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_RUN;
      load_q   <= 1'b0;
      blink_q  <= 1'b0;
      ms_hr_q  <= '0;
      ls_hr_q  <= '0;
      ms_min_q <= '0;
      ls_min_q <= '0;
`ifdef CLOCK_SET_CTRL_TIMEOUT_EN
      idle_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      load_q   <= load_d;
      blink_q  <= blink_d;
      ms_hr_q  <= ms_hr_d;
      ls_hr_q  <= ls_hr_d;
      ms_min_q <= ms_min_d;
      ls_min_q <= ls_min_d;
`ifdef CLOCK_SET_CTRL_TIMEOUT_EN
      idle_q   <= idle_d;
`endif
    end
  end

  // tick passes straight through while running; reset masks it.
  assign cnt_en      = tick & (state_q == ST_RUN) & ~reset;
  assign load        = load_q;
  assign blink       = blink_q;
  assign mode        = state_q;
  assign load_ms_hr  = ms_hr_q;
  assign load_ls_hr  = ls_hr_q;
  assign load_ms_min = ms_min_q;
  assign load_ls_min = ls_min_q;

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 Parameter TIMEOUT_TICKS, default 10, number of idle ticks before an abandoned set session is cancelled; legal range 1..255.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 tick  input  1  one-cycle pulse, once per minute; counting time base.
REQ-005 btn_mode  input  1  one-cycle, debounced pulse; advances the set sequence.
REQ-006 btn_inc  input  1  one-cycle, debounced pulse; increments the field being set.
REQ-007 time_ms_hr/time_ls_hr/time_ms_min/time_ls_min  input  2/4/3/4  current BCD time from the counter.
REQ-008 cnt_en  output  1  count enable to the counter: equals tick while in RUN, else 0.
REQ-009 load  output  1  one-cycle load strobe to the counter.
REQ-010 load_ms_hr/load_ls_hr/load_ms_min/load_ls_min  output  2/4/3/4  shadow BCD time; always driven, valid when load=1.
REQ-011 mode  output  2  00 RUN, 01 SET_HR, 10 SET_MIN, 11 COMMIT.
REQ-012 blink  output  1  display blink for the field being set.

Function
REQ-013 The block SHALL be a 4-state FSM: RUN, SET_HR, SET_MIN, COMMIT.
REQ-014 RUN + btn_mode SHALL go to SET_HR next cycle and copy all four time_* inputs into the shadow registers on that edge.
REQ-015 SET_HR + btn_mode SHALL go to SET_MIN; SET_MIN + btn_mode SHALL go to COMMIT.
REQ-016 COMMIT SHALL last exactly one cycle, with load=1 and shadow on load_*; the next state SHALL be RUN, and load SHALL be 0 in all other states.
REQ-017 In SET_HR, btn_inc SHALL advance the hour shadow by 1 in BCD, 00..23: ls 9->0 with ms+1; 23->00.
REQ-018 In SET_MIN, btn_inc SHALL advance the minute shadow by 1 in BCD, 00..59: ls 9->0 with ms+1; 59->00.
REQ-019 btn_inc SHALL be ignored in RUN and COMMIT.
REQ-020 btn_mode and btn_inc in the same cycle: btn_mode SHALL take effect and btn_inc SHALL be discarded.
REQ-021 tick in any state other than RUN SHALL not reach cnt_en.
REQ-022 blink SHALL toggle on each tick in SET_HR/SET_MIN, be cleared on entry to SET_HR and SET_MIN, and be 0 in RUN and COMMIT.
REQ-023 Shadow registers SHALL hold their value in RUN and COMMIT; no out-of-range BCD value SHALL ever be produced by an increment.

Reset
REQ-024 reset=1 at a clock edge SHALL force state RUN and clear all of the following to 0: mode, load, blink, cnt_en, shadow registers and idle counter.
REQ-025 reset SHALL override btn_mode, btn_inc and tick in the same cycle; reset during SET_*/COMMIT SHALL abort without any load pulse.

Configuration
REQ-026 Macro CLOCK_SET_CTRL_TIMEOUT_EN present: an 8-bit idle counter SHALL clear on entry to SET_HR and on any btn_mode or btn_inc. It SHALL increment on each tick in SET_HR/SET_MIN. On reaching TIMEOUT_TICKS, the FSM SHALL return to RUN without asserting load, discarding the shadow.
REQ-027 Macro absent: no idle counter SHALL exist, and SET_HR/SET_MIN SHALL be held indefinitely until btn_mode.

Verification
REQ-028 The bench SHALL cover these scenarios:
- Time 09:59, RUN, tick -> cnt_en=1 in the same cycle; mode=00.
- btn_mode, 5x btn_inc, btn_mode, 3x btn_inc, btn_mode from time 21:58 -> hours 22,23,00,01,02; minutes 59,00,01. COMMIT: load=1 for one cycle with 02:01 (load_ms_hr=0, load_ls_hr=2, load_ms_min=0, load_ls_min=1); then mode=00.
- SET_MIN with btn_mode and btn_inc in the same cycle -> COMMIT next cycle; minute shadow unchanged.
- SET_HR with 3 ticks -> cnt_en stays 0; blink sequence 1,0,1.
- TIMEOUT_EN, TIMEOUT_TICKS=10, SET_MIN with 10 ticks and no buttons -> RUN after the 10th tick; load never asserted.
- reset asserted in the COMMIT cycle -> next cycle mode=00, load=0, shadow=00:00.
